st7920_serial_rx: RTL and testbench

Receiver for the ST7920 3-wire serial LCD protocol. The block oversamples the serial clock (E pin) and serial data (R/W pin) in the sys_clk domain, hunts for the 5-one sync pattern and deframes each 24-bit frame. Each good frame is presented as one command {rw, rs, data[7:0]}. It serves as the in-fabric bus monitor and loopback checker for the LCD driver path, and as an LCD stand-in for board-level self-test.

---
 rtl/st7920_serial_rx.sv | 138 +++++++++++++
 tb/tb_st7920_serial_rx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/st7920_serial_rx.sv
// ST7920 3-wire serial receiver: oversamples E/RW in the sys_clk domain, hunts the
// five-one sync and deframes each 24-bit frame into a {rw, rs, data} command.
module st7920_serial_rx #(
    parameter int SAMPLE_EDGE    = 0,
    parameter int TIMEOUT_CYCLES = 8192
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        lcd_clk,
    input  logic        lcd_data,
    output logic        cmd_valid,
    output logic        cmd_rw,
    output logic        cmd_rs,
    output logic [7:0]  cmd_data,
    output logic        frame_err,
    output logic        busy,
    output logic [15:0] cmd_count
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {HUNT, HDR, HI, LO} state_t;

    typedef struct packed {
        logic       rw;
        logic       rs;
        logic [7:0] data;
    } cmd_t;

    logic          clk_s1, clk_s2, clk_prev;
    logic          dat_s1, dat_s2;
    logic          samp;
    state_t        state;
    logic [2:0]    ones;
    logic [2:0]    bit_cnt;
    logic [TW-1:0] to_cnt;
    cmd_t          fr;
    cmd_t          cmd_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            clk_s1   <= 1'b0;
            clk_s2   <= 1'b0;
            clk_prev <= 1'b0;
            dat_s1   <= 1'b0;
            dat_s2   <= 1'b0;
        end else begin
            clk_s1   <= lcd_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= lcd_data;
            dat_s2   <= dat_s1;
        end
    end

    // Data and clock share sync depth, so dat_s2 is the bit that belongs to this edge.
    assign samp = (SAMPLE_EDGE != 0) ? (clk_s2 & ~clk_prev) : (~clk_s2 & clk_prev);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= HUNT;
            ones      <= '0;
            bit_cnt   <= '0;
            to_cnt    <= '0;
            fr        <= '0;
            cmd_q     <= '0;
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            cmd_count <= '0;
        end else begin
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            if (state == HUNT) begin
                to_cnt <= '0;
                if (samp) begin
                    if (!dat_s2) begin
                        ones <= '0;
                    end else if (ones == 3'd4) begin
                        ones    <= '0;
                        bit_cnt <= '0;
                        state   <= HDR;
                    end else begin
                        ones <= ones + 3'd1;
                    end
                end
            end else if (samp) begin
                to_cnt  <= '0;
                bit_cnt <= bit_cnt + 3'd1;
                case (state)
                    HDR: begin
                        if (bit_cnt == 3'd0) begin
                            fr.rw <= dat_s2;
                        end else if (bit_cnt == 3'd1) begin
                            fr.rs <= dat_s2;
                        end else if (dat_s2) begin
                            frame_err <= 1'b1;
                            state     <= HUNT;
                        end else begin
                            bit_cnt <= '0;
                            state   <= HI;
                        end
                    end
                    HI, LO: begin
                        // First half of each nibble slot is data, second half must be zero.
                        if (!bit_cnt[2]) begin
                            if (state == HI) fr.data[7:4] <= {fr.data[6:4], dat_s2};
                            else             fr.data[3:0] <= {fr.data[2:0], dat_s2};
                        end else if (dat_s2) begin
                            frame_err <= 1'b1;
                            state     <= HUNT;
                        end else if (bit_cnt == 3'd7) begin
                            if (state == HI) begin
                                state <= LO;
                            end else begin
                                cmd_q     <= fr;
                                cmd_valid <= 1'b1;
                                cmd_count <= cmd_count + 16'd1;
                                state     <= HUNT;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                frame_err <= 1'b1;
                state     <= HUNT;
                ones      <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

    assign cmd_rw   = cmd_q.rw;
    assign cmd_rs   = cmd_q.rs;
    assign cmd_data = cmd_q.data;
    assign busy     = (state != HUNT);

endmodule

// File: tb/tb_st7920_serial_rx.sv
// Randomized bench for st7920_serial_rx: bit streams are driven on the pins and the
// expected command/error sequence is derived by scanning the same stream for frames.
module tb_st7920_serial_rx;
    localparam int TO = 64;
    localparam logic [10:0] ERR_EVT = 11'h400;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        lcd_clk;
    logic        lcd_data;
    logic        cmd_valid, cmd_rw, cmd_rs, frame_err, busy;
    logic [7:0]  cmd_data;
    logic [15:0] cmd_count;

    st7920_serial_rx #(.SAMPLE_EDGE(0), .TIMEOUT_CYCLES(TO)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .lcd_clk(lcd_clk), .lcd_data(lcd_data),
        .cmd_valid(cmd_valid), .cmd_rw(cmd_rw), .cmd_rs(cmd_rs), .cmd_data(cmd_data),
        .frame_err(frame_err), .busy(busy), .cmd_count(cmd_count)
    );

    always #5 sys_clk = ~sys_clk;

    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          evt_cyc = 0;
    int          last_fall = 0;
    int          overlap = 0;
    bit          stim_q[$];
    logic [10:0] exp_q[$];
    logic [10:0] act_q[$];
    logic [15:0] exp_count = '0;
    logic [9:0]  exp_last = '0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (cmd_valid) begin act_q.push_back({1'b0, cmd_rw, cmd_rs, cmd_data}); evt_cyc = cyc; end
        if (frame_err) begin act_q.push_back(ERR_EVT); evt_cyc = cyc; end
        if (cmd_valid && frame_err) overlap++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_fixed(input int k);
        return (k == 7) || (k >= 12 && k <= 15) || (k >= 20);
    endfunction

    // Reference: find five consecutive ones, then judge the next 19 bits by position.
    function automatic void model_stream(input bit q[$]);
        int run, i, k, n;
        bit b, stop;
        logic [9:0] f;
        run = 0; i = 0; n = q.size();
        while (i < n) begin
            b = q[i]; i++;
            run = b ? run + 1 : 0;
            if (run == 5) begin
                run = 0; stop = 0; f = '0; k = 5;
                while (!stop && k < 24) begin
                    if (i + k - 5 >= n) begin
                        exp_q.push_back(ERR_EVT);      // clock stops mid-frame
                        i = n; stop = 1;
                    end else begin
                        b = q[i + k - 5];
                        if (is_fixed(k) && b) begin
                            exp_q.push_back(ERR_EVT);
                            i = i + k - 4; stop = 1;
                        end else begin
                            if (k == 5) f[9] = b;
                            if (k == 6) f[8] = b;
                            if (k >= 8 && k <= 11) f[7 - (k - 8)] = b;
                            if (k >= 16 && k <= 19) f[3 - (k - 16)] = b;
                            k++;
                        end
                    end
                end
                if (!stop) begin
                    exp_q.push_back({1'b0, f});
                    exp_count = exp_count + 16'd1;
                    exp_last = f;
                    i = i + 19;
                end
            end
        end
    endfunction

    function automatic void add_frame(input bit rw, input bit rs, input logic [7:0] d, input int flip);
        logic [23:0] w;
        w = {5'b11111, rw, rs, 1'b0, d[7:4], 4'b0000, d[3:0], 4'b0000};
        if (flip >= 0) w[23 - flip] = ~w[23 - flip];
        for (int j = 23; j >= 0; j--) stim_q.push_back(w[j]);
    endfunction

    function automatic void add_zeros(input int n);
        for (int j = 0; j < n; j++) stim_q.push_back(1'b0);
    endfunction

    task automatic send_bit(input bit b, input int hp);
        @(negedge sys_clk);
        lcd_data = b;
        lcd_clk  = 1'b1;
        repeat (hp) @(negedge sys_clk);
        lcd_clk   = 1'b0;
        last_fall = cyc;
        repeat (hp - 1) @(negedge sys_clk);
    endtask

    task automatic send_stream(input int hp);
        foreach (stim_q[j]) send_bit(stim_q[j], hp);
        model_stream(stim_q);
        stim_q.delete();
    endtask

    task automatic settle_and_compare(input string tag);
        lcd_clk = 1'b0; lcd_data = 1'b0;
        repeat (150) @(negedge sys_clk);
        check({tag, "_nevt"}, act_q.size(), exp_q.size());
        for (int j = 0; j < exp_q.size(); j++)
            if (j < act_q.size()) check($sformatf("%s_evt%0d", tag, j), act_q[j], exp_q[j]);
        check({tag, "_count"}, cmd_count, exp_count);
        check({tag, "_fields"}, {cmd_rw, cmd_rs, cmd_data}, exp_last);
        check({tag, "_idle"}, busy, 0);
        act_q.delete(); exp_q.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, cmd_valid, 0);
        check({tag, "_err"}, frame_err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_fields"}, {cmd_rw, cmd_rs, cmd_data}, 0);
        check({tag, "_count"}, cmd_count, 0);
    endtask

    initial begin
        int hp, lat, idx;
        sys_rst_n = 1'b0; lcd_clk = 1'b0; lcd_data = 1'b0;
        repeat (3) @(negedge sys_clk);
        check_zero_outputs("rst");
        sys_rst_n = 1'b1;
        repeat (3) @(negedge sys_clk);

        // single frame, latency from last driven edge
        add_frame(0, 0, 8'h30, -1);
        send_stream(20);
        lat = evt_cyc - last_fall;
        check("lat_ok", (lat >= 3 && lat <= 5), 1);
        settle_and_compare("f30");

        // two data writes separated by idle clocks
        add_frame(0, 1, 8'h41, -1); add_zeros(24); add_frame(0, 1, 8'h5A, -1);
        send_stream(20);
        settle_and_compare("b2b");

        // header fixed bit corrupted: error only, fields hold
        add_frame(0, 0, 8'hFF, 7);
        send_stream(12);
        settle_and_compare("hdrbad");
        add_frame(0, 0, 8'h0C, -1);
        send_stream(12);
        settle_and_compare("f0c");

        // leading garbage, then a padding-bit error
        stim_q.push_back(1); stim_q.push_back(1); stim_q.push_back(1); stim_q.push_back(0);
        add_frame(1, 0, 8'h01, -1);
        send_stream(8);
        settle_and_compare("garb");
        add_frame(0, 1, 8'h80, 12);
        send_stream(8);
        settle_and_compare("pad13");

        // clock stops after 10 bits
        add_frame(1, 1, 8'hA5, -1);
        stim_q = stim_q[0:9];
        send_stream(20);
        check("to_busy", busy, 1);
        repeat (100) @(negedge sys_clk);
        lat = evt_cyc - last_fall;
        check("to_delay_ok", (lat >= TO + 2 && lat <= TO + 5), 1);
        settle_and_compare("tmo");
        add_frame(0, 1, 8'h77, -1);
        send_stream(10);
        settle_and_compare("posttmo");

        // reset in the middle of a frame
        stim_q.delete();
        add_frame(1, 1, 8'hC3, -1);
        for (int j = 0; j < 15; j++) send_bit(stim_q[j], 10);
        stim_q.delete();
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        check_zero_outputs("midrst");
        check("midrst_noevt", act_q.size(), 0);
        sys_rst_n = 1'b1;
        act_q.delete(); exp_q.delete();
        exp_count = '0; exp_last = '0;
        repeat (3) @(negedge sys_clk);
        check_zero_outputs("postrst");
        add_frame(0, 0, 8'h03, -1);
        send_stream(10);
        settle_and_compare("f03");

        // random frames with random prefixes and occasional corruption
        for (int it = 0; it < 12; it++) begin
            hp = $urandom_range(4, 20);
            for (int j = $urandom_range(0, 5); j > 0; j--) stim_q.push_back(1'($urandom_range(0, 1)));
            idx = -1;
            if ($urandom_range(0, 3) == 0) begin
                idx = $urandom_range(0, 8);
                idx = (idx == 0) ? 7 : (idx <= 4) ? 11 + idx : 15 + idx;
            end
            add_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), idx);
            add_zeros(3);
            send_stream(hp);
            settle_and_compare($sformatf("rnd%0d", it));
        end

        check("no_overlap", overlap, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
